// File: rtl/sprite_bank.sv
// Bank of NUM_SPRITES bouncing rectangles with fixed-priority pixel resolve.
// Optional overlap detector enabled by defining SPRITE_COLLISION_EN.
module sprite_bank #(
    parameter int NUM_SPRITES = 4,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SIZE_W      = 9,
    parameter int DEL_W       = 5,
    parameter int IDX_W       = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [10:0]       X,
    input  logic [10:0]       Y,
    input  logic              VBlank,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic              cfg_en,
    input  logic [10:0]       cfg_x,
    input  logic [10:0]       cfg_y,
    input  logic [DEL_W-1:0]  cfg_dx,
    input  logic [DEL_W-1:0]  cfg_dy,
    input  logic [SIZE_W-1:0] cfg_xsize,
    input  logic [SIZE_W-1:0] cfg_ysize,
    input  logic [11:0]       cfg_rgb,
    output logic              hit,
    output logic [IDX_W-1:0]  hit_idx,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              collide
);

    localparam logic signed [12:0] H_LIM = 13'(H_ACTIVE);
    localparam logic signed [12:0] V_LIM = 13'(V_ACTIVE);

    logic              spr_en  [NUM_SPRITES];
    logic [10:0]       spr_x   [NUM_SPRITES];
    logic [10:0]       spr_y   [NUM_SPRITES];
    logic [DEL_W-1:0]  spr_dx  [NUM_SPRITES];
    logic [DEL_W-1:0]  spr_dy  [NUM_SPRITES];
    logic [SIZE_W-1:0] spr_xs  [NUM_SPRITES];
    logic [SIZE_W-1:0] spr_ys  [NUM_SPRITES];
    logic [11:0]       spr_rgb [NUM_SPRITES];

    logic [10+DEL_W:0] step_x [NUM_SPRITES];
    logic [10+DEL_W:0] step_y [NUM_SPRITES];

    logic                   vblank_q;
    logic                   tick;
    logic [NUM_SPRITES-1:0] hit_vec;
    logic                   any_hit;
    logic [IDX_W-1:0]       win_idx;
    logic [11:0]            win_rgb;

    // One axis of motion: returns {next position, next velocity}.
    function automatic logic [10+DEL_W:0] step_axis(
        input logic [10:0]        pos,
        input logic [DEL_W-1:0]   vel,
        input logic [SIZE_W-1:0]  size,
        input logic signed [12:0] lim
    );
        logic signed [12:0] np;
        logic signed [12:0] vs;
        logic signed [12:0] sz;
        logic signed [12:0] edge_pos;
        logic [10:0]        pos_n;
        logic [DEL_W-1:0]   vel_n;
        vs       = {{(13-DEL_W){vel[DEL_W-1]}}, vel};
        sz       = {{(13-SIZE_W){1'b0}}, size};
        np       = {2'b00, pos} + vs;
        edge_pos = (sz >= lim) ? '0 : lim - sz;
        pos_n    = 11'(np);
        vel_n    = vel;
        if (!vel[DEL_W-1] && vel != '0 && (np + sz) > lim) begin
            pos_n = 11'(edge_pos);
            vel_n = -vel;
        end else if (vel[DEL_W-1] && np < 0) begin
            pos_n = '0;
            vel_n = -vel;
        end
        return {pos_n, vel_n};
    endfunction

    assign tick = VBlank & ~vblank_q;

    always_comb begin
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
            step_x[i] = step_axis(spr_x[i], spr_dx[i], spr_xs[i], H_LIM);
            step_y[i] = step_axis(spr_y[i], spr_dy[i], spr_ys[i], V_LIM);
        end
    end

    // A config write to a sprite takes precedence over its motion on the same tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vblank_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
                spr_en[i]  <= 1'b0;
                spr_x[i]   <= '0;
                spr_y[i]   <= '0;
                spr_dx[i]  <= '0;
                spr_dy[i]  <= '0;
                spr_xs[i]  <= '0;
                spr_ys[i]  <= '0;
                spr_rgb[i] <= '0;
            end
        end else begin
            vblank_q <= VBlank;
            for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
                if (cfg_we && 32'(cfg_idx) == i) begin
                    spr_en[i]  <= cfg_en;
                    spr_x[i]   <= cfg_x;
                    spr_y[i]   <= cfg_y;
                    spr_dx[i]  <= cfg_dx;
                    spr_dy[i]  <= cfg_dy;
                    spr_xs[i]  <= cfg_xsize;
                    spr_ys[i]  <= cfg_ysize;
                    spr_rgb[i] <= cfg_rgb;
                end else if (tick && spr_en[i]) begin
                    {spr_x[i], spr_dx[i]} <= step_x[i];
                    {spr_y[i], spr_dy[i]} <= step_y[i];
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
            hit_vec[i] = spr_en[i]
                && ({1'b0, X} >= {1'b0, spr_x[i]})
                && ({1'b0, X} <  ({1'b0, spr_x[i]} + 12'(spr_xs[i])))
                && ({1'b0, Y} >= {1'b0, spr_y[i]})
                && ({1'b0, Y} <  ({1'b0, spr_y[i]} + 12'(spr_ys[i])));
        end
    end

    always_comb begin
        any_hit = 1'b0;
        win_idx = '0;
        win_rgb = '0;
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
            if (hit_vec[i] && !any_hit) begin
                any_hit = 1'b1;
                win_idx = IDX_W'(i);
                win_rgb = spr_rgb[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit     <= 1'b0;
            hit_idx <= '0;
            red     <= '0;
            green   <= '0;
            blue    <= '0;
        end else begin
            hit     <= any_hit;
            hit_idx <= win_idx;
            red     <= win_rgb[11:8];
            green   <= win_rgb[7:4];
            blue    <= win_rgb[3:0];
        end
    end

`ifdef SPRITE_COLLISION_EN
    logic multi_hit;
    logic seen_hit;

    always_comb begin
        multi_hit = 1'b0;
        seen_hit  = 1'b0;
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
            if (hit_vec[i]) begin
                if (seen_hit) multi_hit = 1'b1;
                seen_hit = 1'b1;
            end
        end
    end

    // Sticky until the frame tick; a same-cycle overlap keeps it set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            collide <= 1'b0;
        end else if (multi_hit) begin
            collide <= 1'b1;
        end else if (tick) begin
            collide <= 1'b0;
        end
    end
`else
    assign collide = 1'b0;
`endif

endmodule
